// File: rtl/cds_idac_pkg.sv
// Shared constants and state type for the segmented current-DAC decoder.
package cds_idac_pkg;

    localparam int N_THERM  = 17;
    localparam int N_BIN    = 6;
    localparam int CODE_MAX = 1151;
    localparam int MSB_W    = 5;
    localparam int SAT_W    = 11;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WARMUP,
        ST_ACTIVE
    } idac_state_t;

endpackage

// File: rtl/idac_therm_decoder.sv
// Combinational binary-to-thermometer decoder for the 17 unary DAC segments.
module idac_therm_decoder
    import cds_idac_pkg::*;
(
    input  logic [MSB_W-1:0]   msb,
    output logic [N_THERM-1:0] therm_en
);

    always_comb begin
        therm_en = '0;
        for (int i = 0; i < N_THERM; i++) begin
            therm_en[i] = (msb > MSB_W'(i));
        end
    end

endmodule

// File: rtl/idac_segment_decoder.sv
// Segmented IDAC code decoder: power-up FSM, code saturation, decode and output stages.
// Optional slew limiting of the unary segments is enabled by defining IDAC_DEC_SLEW_LIMIT_EN.
module idac_segment_decoder
    import cds_idac_pkg::*;
#(
    parameter int WARMUP_CYCLES = 16,
    parameter int CODE_W        = 12
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic               pdb,
    input  logic [CODE_W-1:0]  code,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic               red_ena,
    output logic [N_THERM-1:0] therm_en,
    output logic [N_BIN-1:0]   bin_en,
    output logic               bin0_red_en,
    output logic               sat,
    output logic               active
);

    localparam int CNT_W = $clog2(WARMUP_CYCLES) + 1;

    idac_state_t        state;
    idac_state_t        state_next;
    logic [CNT_W-1:0]   warm_cnt;
    logic [MSB_W-1:0]   dec_msb;
    logic [N_BIN-1:0]   dec_lsb;
    logic [MSB_W-1:0]   out_msb_next;
    logic [N_BIN-1:0]   bin_next;
    logic [N_THERM-1:0] therm_next;
    logic [SAT_W-1:0]   code_sat;
    logic               code_over;
    logic               run;
    logic               transfer;

    assign active   = (state == ST_ACTIVE);
    assign run      = pdb && active;
    // pdb gates the handshake directly so a power-down cycle never accepts a code
    assign transfer = code_valid && code_ready && pdb;

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!pdb) begin
            state_next = ST_OFF;
        end else begin
            case (state)
                ST_OFF:    state_next = ST_WARMUP;
                ST_WARMUP: if (warm_cnt == CNT_W'(WARMUP_CYCLES - 1)) state_next = ST_ACTIVE;
                ST_ACTIVE: state_next = ST_ACTIVE;
                default:   state_next = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            warm_cnt <= '0;
        end else if (pdb && state == ST_WARMUP) begin
            warm_cnt <= warm_cnt + CNT_W'(1);
        end else begin
            warm_cnt <= '0;
        end
    end

    assign code_over = (code > CODE_W'(CODE_MAX));
    assign code_sat  = code_over ? SAT_W'(CODE_MAX) : code[SAT_W-1:0];

    // Decode register: cleared whenever not running so a stale code never reappears, sat is kept
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            dec_msb <= '0;
            dec_lsb <= '0;
            sat     <= 1'b0;
        end else if (!run) begin
            dec_msb <= '0;
            dec_lsb <= '0;
        end else if (transfer) begin
            dec_msb <= code_sat[SAT_W-1:6];
            dec_lsb <= code_sat[5:0];
            sat     <= code_over;
        end
    end

`ifdef IDAC_DEC_SLEW_LIMIT_EN
    logic [MSB_W-1:0] out_msb;
    logic             slew_pending;

    // Step one segment per cycle; the binary part only follows once the unary part has arrived
    always_comb begin
        out_msb_next = out_msb;
        bin_next     = bin_en;
        if (out_msb < dec_msb) begin
            out_msb_next = out_msb + MSB_W'(1);
        end else if (out_msb > dec_msb) begin
            out_msb_next = out_msb - MSB_W'(1);
        end else begin
            bin_next = dec_lsb;
        end
    end

    assign slew_pending = (out_msb != dec_msb) || (bin_en != dec_lsb);
    assign code_ready   = active && !slew_pending;

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            out_msb <= '0;
        end else if (!run) begin
            out_msb <= '0;
        end else begin
            out_msb <= out_msb_next;
        end
    end
`else
    assign out_msb_next = dec_msb;
    assign bin_next     = dec_lsb;
    assign code_ready   = active;
`endif

    idac_therm_decoder u_therm_decoder (
        .msb      (out_msb_next),
        .therm_en (therm_next)
    );

    // Output register keeps every cell enable glitch-free; red_ena is resampled every cycle
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            therm_en    <= '0;
            bin_en      <= '0;
            bin0_red_en <= 1'b0;
        end else if (!run) begin
            therm_en    <= '0;
            bin_en      <= '0;
            bin0_red_en <= 1'b0;
        end else begin
            therm_en    <= therm_next;
            bin_en      <= bin_next;
            bin0_red_en <= bin_next[0] & red_ena;
        end
    end

endmodule

// File: tb/tb_idac_segment_decoder.sv
// Directed self-checking bench for idac_segment_decoder (default build or IDAC_DEC_SLEW_LIMIT_EN).
module tb_idac_segment_decoder;

    logic        clkin = 1'b0;
    logic        rstb;
    logic        pdb;
    logic [11:0] code;
    logic        code_valid;
    logic        code_ready;
    logic        red_ena;
    logic [16:0] therm_en;
    logic [5:0]  bin_en;
    logic        bin0_red_en;
    logic        sat;
    logic        active;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clkin = ~clkin;

    idac_segment_decoder #(
        .WARMUP_CYCLES (16),
        .CODE_W        (12)
    ) dut (
        .clkin       (clkin),
        .rstb        (rstb),
        .pdb         (pdb),
        .code        (code),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .red_ena     (red_ena),
        .therm_en    (therm_en),
        .bin_en      (bin_en),
        .bin0_red_en (bin0_red_en),
        .sat         (sat),
        .active      (active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [16:0] t, input logic [5:0] b, input logic r);
        check({tag, "_therm"}, 32'(therm_en), 32'(t));
        check({tag, "_bin"}, 32'(bin_en), 32'(b));
        check({tag, "_red"}, 32'(bin0_red_en), 32'(r));
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    function automatic logic [16:0] tmask(input int k);
        logic [31:0] m;
        m = (32'd1 << k) - 32'd1;
        return m[16:0];
    endfunction

    // Single-cycle handshake; the transfer happens on the edge inside this task
    task automatic send(input logic [11:0] c);
        code       = c;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
    endtask

    task automatic warmup(input string tag);
        for (int k = 0; k < 16; k++) begin
            step();
            check({tag, "_active"}, 32'(active), 32'd0);
            check({tag, "_ready"}, 32'(code_ready), 32'd0);
            check({tag, "_therm"}, 32'(therm_en), 32'd0);
        end
        step();
        check({tag, "_done_active"}, 32'(active), 32'd1);
        check({tag, "_done_ready"}, 32'(code_ready), 32'd1);
    endtask

    initial begin
        rstb       = 1'b0;
        pdb        = 1'b0;
        code       = '0;
        code_valid = 1'b0;
        red_ena    = 1'b0;
        #12;
        check_outs("rst", 17'h0, 6'h0, 1'b0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_ready", 32'(code_ready), 32'd0);

        step();
        rstb = 1'b1;
        step();
        check("off_hold_active", 32'(active), 32'd0);

        pdb = 1'b1;
        warmup("warm");

`ifdef IDAC_DEC_SLEW_LIMIT_EN
        send(12'd0);
        check("slew_c0_ready", 32'(code_ready), 32'd1);
        send(12'd1151);
        check("slew_start_ready", 32'(code_ready), 32'd0);
        check("slew_start_therm", 32'(therm_en), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            check("slew_up_therm", 32'(therm_en), 32'(tmask(k)));
            check("slew_up_bin", 32'(bin_en), 32'd0);
            check("slew_up_ready", 32'(code_ready), 32'd0);
        end
        step();
        check_outs("slew_done", 17'h1FFFF, 6'h3F, 1'b0);
        check("slew_done_ready", 32'(code_ready), 32'd1);

        send(12'd0);
        check("slew_down_ready", 32'(code_ready), 32'd0);
        check("slew_down_hold", 32'(therm_en), 32'h1FFFF);
        repeat (3) step();
        check_outs("slew_down3", tmask(14), 6'h3F, 1'b0);

        pdb = 1'b0;
        step();
        check_outs("slew_pdb", 17'h0, 6'h0, 1'b0);
        check("slew_pdb_active", 32'(active), 32'd0);
        pdb = 1'b1;
        warmup("slew_rewarm");
        check_outs("slew_rewarm_outs", 17'h0, 6'h0, 1'b0);
`else
        send(12'd200);
        check("c200_latency", 32'(therm_en), 32'd0);
        check("c200_sat", 32'(sat), 32'd0);
        step();
        check_outs("c200", 17'h00007, 6'b001000, 1'b0);
        check("c200_ready", 32'(code_ready), 32'd1);
        repeat (2) step();
        check("c200_hold", 32'(therm_en), 32'h7);

        send(12'd4095);
        check("c4095_sat", 32'(sat), 32'd1);
        check("c4095_latency", 32'(therm_en), 32'h7);
        step();
        check_outs("c4095", 17'h1FFFF, 6'h3F, 1'b0);

        send(12'd1151);
        check("c1151_sat", 32'(sat), 32'd0);
        step();
        check_outs("c1151", 17'h1FFFF, 6'h3F, 1'b0);

        send(12'd1);
        step();
        check_outs("c1_red0", 17'h0, 6'h01, 1'b0);
        red_ena = 1'b1;
        check("red_lag", 32'(bin0_red_en), 32'd0);
        step();
        check_outs("red_on", 17'h0, 6'h01, 1'b1);
        red_ena = 1'b0;
        step();
        check_outs("red_off", 17'h0, 6'h01, 1'b0);

        send(12'd64);
        step();
        check_outs("c64", 17'h00001, 6'h00, 1'b0);
        send(12'd63);
        step();
        check_outs("c63", 17'h00000, 6'h3F, 1'b0);

        send(12'd4095);
        step();
        check("pre_pdb_sat", 32'(sat), 32'd1);

        pdb        = 1'b0;
        code       = 12'd100;
        code_valid = 1'b1;
        step();
        check_outs("pdb_off", 17'h0, 6'h0, 1'b0);
        check("pdb_off_sat", 32'(sat), 32'd1);
        check("pdb_off_active", 32'(active), 32'd0);
        check("pdb_off_ready", 32'(code_ready), 32'd0);
        pdb = 1'b1;
        warmup("rewarm");
        code_valid = 1'b0;
        check("rewarm_sat_held", 32'(sat), 32'd1);
        step();
        check_outs("rewarm_discard", 17'h0, 6'h0, 1'b0);
        check("rewarm_sat_still", 32'(sat), 32'd1);

        send(12'd1088);
        check("c1088_sat", 32'(sat), 32'd0);
        step();
        check_outs("c1088", 17'h1FFFF, 6'h00, 1'b0);
`endif

        #2;
        rstb = 1'b0;
        #1;
        check_outs("async_rst", 17'h0, 6'h0, 1'b0);
        check("async_rst_sat", 32'(sat), 32'd0);
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_ready", 32'(code_ready), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
